if_id_skid_reg: RTL and testbench

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

---
 rtl/if_id_skid_reg_if.sv | 32 +++
 rtl/if_id_skid_reg.sv | 97 +++++++++
 tb/tb_if_id_skid_reg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_if.sv
// Fetch/decode boundary bundle for the IF/ID skid register.
// "master" is the surrounding pipeline; "slave" is the skid register itself.
interface if_id_skid_reg_if #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [ADDR_W-1:0]  in_pc;
   logic [ADDR_W-1:0]  in_pc_plus4;
   logic               flush;
   logic               cnt_clr;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [ADDR_W-1:0]  out_pc_plus4;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;

   modport master (
      output in_valid, in_instr, in_pc, in_pc_plus4, flush, cnt_clr, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_pc_plus4, stall_cnt, flush_cnt
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_pc_plus4, flush, cnt_clr, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_pc_plus4, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, flush, and saturating
// stall/flush statistics counters.
module if_id_skid_reg #(
   parameter int                 INSTR_W   = 32,
   parameter int                 ADDR_W    = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 CNT_W     = 16
) (
   input logic              clk,
   input logic              rst_n,
   if_id_skid_reg_if.slave  bus
);

   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic [ADDR_W-1:0]  pc_plus4;
   } entry_t;

   localparam entry_t EMPTY = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_ent;
   logic   accept;
   logic   stall;
   logic [1:0] inc;

   assign in_ent = '{valid: 1'b1, instr: bus.in_instr, pc: bus.in_pc, pc_plus4: bus.in_pc_plus4};
   assign accept = bus.in_valid && !skid_q.valid;
   assign stall  = main_q.valid && !bus.out_ready;
   assign inc    = {bus.flush, stall};

   // SKID can only be full while MAIN is full, so out_ready alone means consume there.
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (bus.flush) begin
         main_d = EMPTY;
         skid_d = EMPTY;
      end else if (skid_q.valid) begin
         if (bus.out_ready) begin
            main_d = skid_q;
            skid_d = EMPTY;
         end
      end else if (!main_q.valid || bus.out_ready) begin
         main_d = accept ? in_ent : EMPTY;
      end else if (accept) begin
         skid_d = in_ent;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= EMPTY;
         skid_q <= EMPTY;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   // Counter 0 tracks stall cycles, counter 1 tracks flush cycles.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (bus.cnt_clr) begin
               cnt_d = '0;
            end else if (inc[gi] && !(&cnt_q)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   assign bus.in_ready     = !skid_q.valid;
   assign bus.out_valid    = main_q.valid;
   assign bus.out_instr    = main_q.instr;
   assign bus.out_pc       = main_q.pc;
   assign bus.out_pc_plus4 = main_q.pc_plus4;
   assign bus.stall_cnt    = g_cnt[0].cnt_q;
   assign bus.flush_cnt    = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a queue-based occupancy model checked every cycle,
// plus directed literal checks; a CNT_W=2 twin shares the stimulus for saturation.
module tb_if_id_skid_reg;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_id_skid_reg_if                bus  ();
   if_id_skid_reg_if #(.CNT_W(2))   sbus ();

   assign sbus.in_valid    = bus.in_valid;
   assign sbus.in_instr    = bus.in_instr;
   assign sbus.in_pc       = bus.in_pc;
   assign sbus.in_pc_plus4 = bus.in_pc_plus4;
   assign sbus.flush       = bus.flush;
   assign sbus.cnt_clr     = bus.cnt_clr;
   assign sbus.out_ready   = bus.out_ready;

   if_id_skid_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   if_id_skid_reg #(.CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the block is a FIFO of depth 2; head is the decode entry.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ent_t;

   ent_t mq[$];
   int   m_stall = 0, m_flush = 0, s_stall = 0, s_flush = 0;
   bit   m_acc, m_cons, m_stl;

   function automatic int sat_inc(input int v, input int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_stall = 0; m_flush = 0; s_stall = 0; s_flush = 0;
      end else begin
         m_acc  = bus.in_valid && (mq.size() < 2);
         m_cons = (mq.size() > 0) && bus.out_ready;
         m_stl  = (mq.size() > 0) && !bus.out_ready;
         if (bus.cnt_clr) begin
            m_stall = 0; m_flush = 0; s_stall = 0; s_flush = 0;
         end else begin
            if (m_stl) begin
               m_stall = sat_inc(m_stall, 65535);
               s_stall = sat_inc(s_stall, 3);
            end
            if (bus.flush) begin
               m_flush = sat_inc(m_flush, 65535);
               s_flush = sat_inc(s_flush, 3);
            end
         end
         if (bus.flush) begin
            mq.delete();
         end else begin
            if (m_cons) void'(mq.pop_front());
            if (m_acc) mq.push_back('{bus.in_instr, bus.in_pc, bus.in_pc_plus4});
         end
      end
   end

   logic        e_valid;
   logic [31:0] e_instr, e_pc, e_pc4;

   always @(negedge clk) begin
      e_valid = mq.size() > 0;
      e_instr = e_valid ? mq[0].instr : 32'h0;
      e_pc    = e_valid ? mq[0].pc    : 32'h0;
      e_pc4   = e_valid ? mq[0].pc4   : 32'h0;
      chk("out_valid",    bus.out_valid,    e_valid);
      chk("in_ready",     bus.in_ready,     mq.size() < 2);
      chk("out_instr",    bus.out_instr,    e_instr);
      chk("out_pc",       bus.out_pc,       e_pc);
      chk("out_pc_plus4", bus.out_pc_plus4, e_pc4);
      chk("stall_cnt",    bus.stall_cnt,    m_stall);
      chk("flush_cnt",    bus.flush_cnt,    m_flush);
      chk("sat_out_instr", sbus.out_instr,  e_instr);
      chk("sat_stall_cnt", sbus.stall_cnt,  s_stall);
      chk("sat_flush_cnt", sbus.flush_cnt,  s_flush);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid    = 1'b1;
      bus.in_instr    = instr;
      bus.in_pc       = pc;
      bus.in_pc_plus4 = pc + 32'd4;
   endtask

   task automatic idle_in();
      bus.in_valid    = 1'b0;
      bus.in_instr    = 32'h0;
      bus.in_pc       = 32'h0;
      bus.in_pc_plus4 = 32'h0;
   endtask

   initial begin
      idle_in();
      bus.flush     = 1'b0;
      bus.cnt_clr   = 1'b0;
      bus.out_ready = 1'b0;

      #3;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready",  bus.in_ready,  1'b1);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_stall_cnt", bus.stall_cnt, 16'h0);
      #9 rst_n = 1'b1;

      // Streaming
      bus.out_ready = 1'b1;
      offer(32'hA000_000A, 32'h100); step();
      chk("stream_A", bus.out_instr, 32'hA000_000A);
      offer(32'hB000_000B, 32'h104); step();
      chk("stream_B", bus.out_instr, 32'hB000_000B);
      chk("stream_B_pc4", bus.out_pc_plus4, 32'h108);
      offer(32'hC000_000C, 32'h108); step();
      chk("stream_C", bus.out_instr, 32'hC000_000C);
      chk("stream_ready", bus.in_ready, 1'b1);
      idle_in(); step();
      chk("drain_valid", bus.out_valid, 1'b0);
      chk("drain_instr", bus.out_instr, 32'h0);
      chk("drain_pc",    bus.out_pc,    32'h0);
      chk("stream_stall", bus.stall_cnt, 16'd0);

      // Skid
      bus.out_ready = 1'b0;
      offer(32'hA1, 32'h200); step();
      offer(32'hB1, 32'h204); step();
      chk("skid_ready", bus.in_ready, 1'b0);
      chk("skid_main",  bus.out_instr, 32'hA1);
      offer(32'hC1, 32'h208); step(); step();
      bus.out_ready = 1'b1; step();
      chk("skid_out_B", bus.out_instr, 32'hB1);
      step();
      chk("skid_out_C", bus.out_instr, 32'hC1);
      idle_in(); step();
      chk("skid_stall", bus.stall_cnt, 16'd3);

      // Flush with both entries held
      bus.out_ready = 1'b0;
      offer(32'hA2, 32'h300); step();
      offer(32'hB2, 32'h304); step();
      offer(32'hC2, 32'h308); bus.flush = 1'b1; step();
      chk("flush_valid", bus.out_valid, 1'b0);
      chk("flush_instr", bus.out_instr, 32'h0);
      chk("flush_ready", bus.in_ready,  1'b1);
      chk("flush_cnt1",  bus.flush_cnt, 16'd1);
      chk("flush_stall", bus.stall_cnt, 16'd5);
      // Flush overrides an accept into an empty block
      bus.out_ready = 1'b1;
      offer(32'hD2, 32'h30C); step();
      chk("flush_acc_valid", bus.out_valid, 1'b0);
      bus.flush = 1'b0; idle_in(); step();
      chk("flush_no_C", bus.out_valid, 1'b0);

      // Saturation on the CNT_W=2 twin
      bus.cnt_clr = 1'b1; step();
      bus.cnt_clr = 1'b0;
      chk("clr_flush", bus.flush_cnt, 16'd0);
      bus.out_ready = 1'b0;
      offer(32'hA3, 32'h400); step();
      idle_in();
      step(); chk("sat_1", sbus.stall_cnt, 2'd1);
      step(); chk("sat_2", sbus.stall_cnt, 2'd2);
      step(); chk("sat_3", sbus.stall_cnt, 2'd3);
      step(); chk("sat_4", sbus.stall_cnt, 2'd3);
      step(); chk("sat_5", sbus.stall_cnt, 2'd3);
      bus.cnt_clr = 1'b1; step();
      bus.cnt_clr = 1'b0;
      chk("sat_clr", sbus.stall_cnt, 2'd0);
      chk("clr_keeps_main", bus.out_instr, 32'hA3);

      // Async reset with SKID full
      offer(32'hB3, 32'h404); step();
      chk("pre_rst_ready", bus.in_ready, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 1'b0);
      chk("arst_ready", bus.in_ready,  1'b1);
      chk("arst_instr", bus.out_instr, 32'h0);
      chk("arst_pc4",   bus.out_pc_plus4, 32'h0);
      offer(32'hD4, 32'h500);
      bus.out_ready = 1'b1;
      #4 rst_n = 1'b1;
      step();
      chk("post_rst_valid", bus.out_valid, 1'b1);
      chk("post_rst_instr", bus.out_instr, 32'hD4);

      // Mixed traffic: order and counters tracked by the model
      for (int i = 0; i < 40; i++) begin
         if (i % 3 != 0) offer(32'hE000_0000 + i, 32'h1000 + 4 * i);
         else idle_in();
         bus.out_ready = (i % 4 != 1) && (i % 7 != 3);
         bus.flush     = (i >= 11 && i <= 14);
         step();
      end
      bus.flush = 1'b0;
      idle_in();
      bus.out_ready = 1'b1;
      step(); step(); step();
      chk("end_sat_flush", sbus.flush_cnt, 2'd3);
      chk("end_empty",     bus.out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
